// File: rtl/seq_alu_if.sv
// Operand/result bundle between operand entry and the seq_alu core.
// ALU_OVERFLOW_EN adds the ovf result bit.
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       mode;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] rem;
    logic             neg;
    logic             div_by_zero;
`ifdef ALU_OVERFLOW_EN
    logic             ovf;

    modport master (
        output start, a, b, mode,
        input  busy, done, out, rem, neg, div_by_zero, ovf
    );
    modport slave (
        input  start, a, b, mode,
        output busy, done, out, rem, neg, div_by_zero, ovf
    );
`else
    modport master (
        output start, a, b, mode,
        input  busy, done, out, rem, neg, div_by_zero
    );
    modport slave (
        input  start, a, b, mode,
        output busy, done, out, rem, neg, div_by_zero
    );
`endif
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle sign-magnitude ALU: ADD/SUB in one cycle, shift-add MUL and
// restoring DIV one bit per cycle. ALU_OVERFLOW_EN adds the ovf result bit.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    seq_alu_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             neg_q, neg_d;
    logic             dbz_q, dbz_d;
    logic             wr_res;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   dq_q, dq_d;
    logic [WIDTH-1:0]   prem_q, prem_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;

    logic [WIDTH-1:0]   add_sum;
    logic [WIDTH-1:0]   sub_ab;
    logic [WIDTH-1:0]   sub_ba;
    logic               b_gt_a;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic [WIDTH-1:0]   r_step;
    logic [WIDTH-1:0]   q_step;

`ifdef ALU_OVERFLOW_EN
    logic add_c;
    logic ovf_q, ovf_d;
    assign {add_c, add_sum} = {1'b0, bus.a} + {1'b0, bus.b};
`else
    assign add_sum = bus.a + bus.b;
`endif

    assign sub_ab = bus.a - bus.b;
    assign sub_ba = bus.b - bus.a;
    assign b_gt_a = bus.b > bus.a;

    // One multiplier bit per cycle, LSB first; multiplicand pre-shifted.
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Restoring step: shift in next dividend bit, keep the difference if it did not borrow.
    assign rem_sh   = {prem_q, dq_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, dvsr_q};
    assign r_step   = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
    assign q_step   = {dq_q[WIDTH-2:0], ~rem_diff[WIDTH]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            rem_q   <= '0;
            neg_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            neg_q   <= neg_d;
            dbz_q   <= dbz_d;
        end
    end

    // Iteration working registers are fully loaded on acceptance, so no reset.
    always_ff @(posedge clk) begin
        acc_q    <= acc_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        dq_q     <= dq_d;
        prem_q   <= prem_d;
        dvsr_q   <= dvsr_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        dbz_d    = dbz_q;
        wr_res   = 1'b0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        dq_d     = dq_q;
        prem_d   = prem_q;
        dvsr_d   = dvsr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dbz_d = 1'b0;
                    cnt_d = '0;
                    case (bus.mode)
                        3'b000: begin
                            out_d   = add_sum;
                            rem_d   = '0;
                            neg_d   = 1'b0;
                            wr_res  = 1'b1;
                            state_d = S_DONE;
                        end
                        3'b001: begin
                            out_d   = b_gt_a ? sub_ba : sub_ab;
                            rem_d   = '0;
                            neg_d   = b_gt_a;
                            wr_res  = 1'b1;
                            state_d = S_DONE;
                        end
                        3'b010: begin
                            acc_d    = '0;
                            mcand_d  = {{WIDTH{1'b0}}, bus.a};
                            mplier_d = bus.b;
                            state_d  = S_MUL;
                        end
                        3'b011: begin
                            if (bus.b == '0) begin
                                out_d   = '1;
                                rem_d   = bus.a;
                                neg_d   = 1'b0;
                                dbz_d   = 1'b1;
                                wr_res  = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                dq_d    = bus.a;
                                prem_d  = '0;
                                dvsr_d  = bus.b;
                                state_d = S_DIV;
                            end
                        end
                        default: begin
                            out_d   = '0;
                            rem_d   = '0;
                            neg_d   = 1'b0;
                            wr_res  = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    out_d   = acc_step[WIDTH-1:0];
                    rem_d   = '0;
                    neg_d   = 1'b0;
                    wr_res  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                dq_d   = q_step;
                prem_d = r_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    out_d   = q_step;
                    rem_d   = r_step;
                    neg_d   = 1'b0;
                    wr_res  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    always_comb begin
        ovf_d = 1'b0;
        case (state_q)
            S_IDLE:  ovf_d = (bus.mode == 3'b000) ? add_c : 1'b0;
            S_MUL:   ovf_d = |acc_step[2*WIDTH-1:WIDTH];
            default: ovf_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (wr_res) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.out         = out_q;
    assign bus.rem         = rem_q;
    assign bus.neg         = neg_q;
    assign bus.div_by_zero = dbz_q;
endmodule
